// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART/ALU package: arbiter state encoding and default byte width.
package uart_tx_arbiter_pkg;

    localparam int unsigned NB_DATA_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_TX = 2'd2,
        HOLD    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo N_REQ.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    // Scan from the farthest offset down so the closest one to rr_ptr wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pick  = '0;
        idx   = '0;
        for (int unsigned off = N_REQ; off > 0; off--) begin
            idx = PTR_W'((32'(rr_ptr) + off - 1) % N_REQ);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto a single UART transmitter with
// frame locking (owner keeps TX until its last byte) and a HOLD timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NB_DATA      = NB_DATA_DEFAULT,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned HOLD_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*NB_DATA-1:0] req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         grant,
    input  logic                     tx_done_tick,
    output logic                     tx_start,
    output logic [NB_DATA-1:0]       tx_data,
    output logic                     timeout_err
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

    arb_state_t         state, state_next;
    logic [PTR_W-1:0]   rr_ptr, ptr_after;
    logic [N_REQ-1:0]   grant_q, pick, ack_vec;
    logic               pick_valid, own_req, last_q;
    logic [NB_DATA-1:0] tx_data_q, mux_data;
    logic               mux_last;
    logic [CNT_W-1:0]   hold_cnt;
    logic               release_own, clear_grant, hold_clr, hold_inc;

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .valid  (pick_valid)
    );

    assign own_req = |(req & grant_q);
    assign req_ack = ack_vec;
    assign grant   = grant_q;
    assign tx_data = tx_data_q;

    // Next-state and control decode; pulses are gated off while reset is asserted.
    always_comb begin
        state_next  = state;
        ack_vec     = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        release_own = 1'b0;
        clear_grant = 1'b0;
        hold_clr    = 1'b0;
        hold_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    ack_vec    = pick;
                    state_next = START;
                end
            end
            START: begin
                tx_start   = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) begin
                    if (last_q) begin
                        release_own = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        hold_clr   = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (own_req) begin
                    ack_vec    = grant_q;
                    hold_clr   = 1'b1;
                    state_next = START;
                end else if (hold_cnt == CNT_W'(HOLD_TIMEOUT)) begin
                    timeout_err = 1'b1;
                    release_own = 1'b1;
                    state_next  = IDLE;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: begin
                clear_grant = 1'b1;
                state_next  = IDLE;
            end
        endcase
        if (reset) begin
            ack_vec     = '0;
            tx_start    = 1'b0;
            timeout_err = 1'b0;
        end
    end

    // Data/last mux for the acknowledged requester and the pointer past the owner.
    always_comb begin
        mux_data  = '0;
        mux_last  = 1'b0;
        ptr_after = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ack_vec[i]) begin
                mux_data = req_data[i*NB_DATA +: NB_DATA];
                mux_last = req_last[i];
            end
            if (grant_q[i]) begin
                ptr_after = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    // State, ownership, latched byte and hold counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state <= state_next;
            if (|ack_vec) begin
                grant_q   <= ack_vec;
                tx_data_q <= mux_data;
                last_q    <= mux_last;
            end
            if (release_own) begin
                grant_q <= '0;
                rr_ptr  <= ptr_after;
            end
            if (clear_grant) begin
                grant_q <= '0;
            end
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, meaning byte width.
REQ-002 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have parameter HOLD_TIMEOUT, default 255, meaning max cycles in HOLD before forced release.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester byte-valid, held until ack.
REQ-007 SHALL have port req_data  input  N_REQ*NB_DATA  byte of requester i at bits [i*NB_DATA +: NB_DATA].
REQ-008 SHALL have port req_last  input  N_REQ  byte ends requester's frame.
REQ-009 SHALL have port req_ack  output  N_REQ  one-cycle pulse, byte accepted.
REQ-010 SHALL have port grant  output  N_REQ  one-hot owner of TX, zero when free.
REQ-011 SHALL have port tx_done_tick  input  1  UART TX byte finished.
REQ-012 SHALL have port tx_start  output  1  one-cycle start pulse to UART TX.
REQ-013 SHALL have port tx_data  output  NB_DATA  byte to UART TX, registered.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on HOLD timeout.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_TX, HOLD.
REQ-016 IDLE: if any req, SHALL select the first set req at or after rr_ptr, scanning upward and wrapping modulo N_REQ.
REQ-017 IDLE with a selection: req_ack[sel] SHALL be high combinationally in that cycle; data, last flag and grant SHALL be latched at the edge; next state START.
REQ-018 START: tx_start SHALL be 1 for exactly one cycle with tx_data = latched byte; next state WAIT_TX.
REQ-019 WAIT_TX: on tx_done_tick, latched last=1 SHALL clear grant, set rr_ptr = (sel+1) mod N_REQ, and go to IDLE.
REQ-020 WAIT_TX: on tx_done_tick, latched last=0 SHALL go to HOLD with grant kept and hold counter cleared.
REQ-021 HOLD: only req[sel] SHALL be considered; when set, ack/latch as REQ-017, go START, and clear the counter.
REQ-022 HOLD: the counter SHALL increment each cycle req[sel] is low; at HOLD_TIMEOUT it SHALL pulse timeout_err, clear grant, advance rr_ptr as REQ-019, and go to IDLE.
REQ-023 Latency: req in IDLE at cycle 0 -> ack at cycle 0, tx_start at cycle 1.
REQ-024 Latency: tx_done_tick at cycle k -> next ack no earlier than k+1, tx_start at k+2.
REQ-025 tx_done_tick outside WAIT_TX SHALL be ignored.
REQ-026 At most one req_ack bit SHALL be high per cycle; ack SHALL never be issued in START or WAIT_TX.
REQ-027 Requests from non-owners during START/WAIT_TX/HOLD SHALL be held off, not lost; fairness: no requester waits more than N_REQ-1 frames.
REQ-028 grant SHALL be stable from the ack edge until release; tx_data SHALL change only at an ack edge.
REQ-029 Undefined state encodings SHALL return to IDLE with grant cleared.

Reset
REQ-030 On reset, state SHALL be IDLE and rr_ptr, grant, tx_data, and hold counter SHALL be 0.
REQ-031 On reset, tx_start, req_ack and timeout_err SHALL be 0 in the reset cycle.
REQ-032 Reset mid-frame SHALL abandon the frame; a byte already in the UART TX is not recalled, and its later tx_done_tick is ignored per REQ-025.

Structure
REQ-033 The state encoding (2-bit) and default NB_DATA SHALL live in the shared UART/ALU package.
REQ-034 The round-robin selection SHALL be one combinational sub-module, rr_picker (inputs req, rr_ptr; outputs one-hot pick, valid).

Verification
REQ-035 Single request: req[2]=1, data 0x5A, last=1 in IDLE -> ack[2] same cycle, tx_start next cycle with tx_data=0x5A, grant=0 after tx_done_tick.
REQ-036 Contention: req=4'b1011 all last=1, ptr=0 -> service order 0,1,3, then 0 again if still requesting.
REQ-037 Frame lock: req[1] sends 0x11(last=0), 0x22(last=1) while req[0] held high -> bytes 0x11,0x22 consecutive, then requester 0 served.
REQ-038 Timeout: req[3] sends byte last=0 then drops req -> timeout_err pulse exactly HOLD_TIMEOUT cycles into HOLD, grant=0, IDLE.
REQ-039 Reset during WAIT_TX, then spurious tx_done_tick -> no tx_start or ack, all outputs 0, ptr=0.
REQ-040 Spurious tx_done_tick in IDLE/HOLD -> no state change; randomized run checks one-hot grant and single ack per cycle.
